bit_serial_adder: RTL and testbench
===================================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to add; sampled only in IDLE.
REQ-005 SHALL have port a_in, input, WIDTH, operand A; captured on an accepted start.
REQ-006 SHALL have port b_in, input, WIDTH, operand B; captured on an accepted start.
REQ-007 SHALL have port cin_in, input, 1, carry-in; captured on an accepted start.
REQ-008 SHALL have port busy, output, 1, high while in SHIFT.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum_out, output, WIDTH, the result, held until the next accepted start.
REQ-011 SHALL have port cout_out, output, 1, final carry, held with sum_out.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL follow these transitions:
- IDLE->SHIFT on start=1.
- SHIFT->DONE after exactly WIDTH shift cycles.
- DONE->IDLE unconditionally.
REQ-014 SHALL, on an accepted start, load the A and B shift registers and load the carry flip-flop with cin_in.
REQ-015 SHALL, in each SHIFT cycle:
- apply the LSBs of A and B and the carry flip-flop to one 1-bit full adder;
- shift the sum bit into the MSB of the result register;
- shift A and B right;
- store the adder carry in the carry flip-flop.
REQ-016 SHALL count SHIFT cycles with a bit counter of width clog2(WIDTH)+1, cleared on start; the terminal count is WIDTH-1.
REQ-017 SHALL update sum_out and cout_out from the result register and carry flip-flop on entry to DONE.
REQ-018 SHALL assert done only in DONE, i.e. WIDTH+1 cycles after the accepting edge.
REQ-019 SHALL ignore start in SHIFT and DONE; no queuing, and the in-flight operation is unaffected.
REQ-020 SHALL compute (A+B+cin) mod 2^WIDTH, with cout_out equal to bit WIDTH of the full sum.
REQ-021 SHALL, when start is held high, accept it again in the IDLE cycle after DONE (back-to-back throughput of one add per WIDTH+2 cycles).

Reset
REQ-022 SHALL, on rst_n low at any time including mid-SHIFT, go to IDLE and clear every register, with outputs busy=0, done=0, sum_out=0, cout_out=0.
REQ-023 SHALL discard any partial result on reset and SHALL NOT pulse done for an aborted operation.

Configuration
REQ-024 SHALL, when SERIAL_ADD_OVF_EN is defined, add output ovf_out (1 bit): signed overflow, equal to the carry into the MSB XOR the carry out, registered with sum_out and reset to 0.
REQ-025 SHALL, when SERIAL_ADD_OVF_EN is undefined, omit the ovf_out port and its logic, with all other behaviour identical.

Structure
REQ-026 SHALL take the FSM state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH from the shared serial_arith package/header.
REQ-027 SHALL instantiate the existing 1-bit full adder sub-module fa_decoder (a, b, cin -> sum, carry) as its only sub-module.

Verification
REQ-028 SHALL pass (WIDTH=8): a=0x0F, b=0x01, cin=0 -> done at cycle 9 after start, sum_out=0x10, cout_out=0.
REQ-029 SHALL pass: a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout_out=1; and a=0xFF, b=0x00, cin=1 -> sum_out=0x00, cout_out=1.
REQ-030 SHALL pass (with SERIAL_ADD_OVF_EN): a=0x7F, b=0x01 -> sum_out=0x80, ovf_out=1; a=0x80, b=0x80 -> sum_out=0x00, cout_out=1, ovf_out=1.
REQ-031 SHALL pass: start pulsed at cycle 3 of a busy add of 0x12+0x34 -> result 0x46 unchanged, exactly one done pulse.
REQ-032 SHALL pass: rst_n low at cycle 4 of SHIFT -> busy=0, sum_out=0, no done; a new add of 0x05+0x03 afterwards -> 0x08.
REQ-033 SHALL pass: start held high for 30 cycles -> done pulses every 10 cycles with correct results.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared constants for the serial arithmetic blocks.
//   ST_IDLE/ST_SHIFT/ST_DONE - FSM state encodings
//   DEFAULT_WIDTH            - default operand width
package serial_arith_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
endpackage

// File: rtl/fa_decoder.sv
// fa_decoder: combinational 1-bit full adder.
//   a, b, cin -> sum, carry
module fa_decoder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, one bit per clock, WIDTH+2 cycles per add.
//   clk, rst_n (async, active-low)
//   start, a_in, b_in, cin_in  - request and operands, captured in IDLE
//   busy, done                 - busy high in SHIFT, done one-cycle pulse in DONE
//   sum_out, cout_out          - result and carry, held until the next result
//   ovf_out                    - signed overflow, only when SERIAL_ADD_OVF_EN is defined
module bit_serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf_out,
`endif
    output logic             cout_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] res_nxt;

    fa_decoder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_s),
        .carry (fa_c)
    );

    assign res_nxt = {fa_s, res[WIDTH-1:1]};
    assign busy    = (state == ST_SHIFT);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_out  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    a_sr  <= a_in;
                    b_sr  <= b_in;
                    carry <= cin_in;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    res   <= res_nxt;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    // on the MSB cycle the carry flop holds the carry into the MSB
                    if (cnt == LAST) begin
                        state    <= ST_DONE;
                        sum_out  <= res_nxt;
                        cout_out <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_out  <= carry ^ fa_c;
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard bench for bit_serial_adder (WIDTH=8).
module tb_bit_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       cin_in = 1'b0;
    logic       busy, done, cout_out;
    logic [7:0] sum_out;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf_out;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;
    exp_t sb[$];

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
`ifdef SERIAL_ADD_OVF_EN
        .ovf_out  (ovf_out),
`endif
        .cout_out (cout_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", {24'd0, sum_out}, {24'd0, e.s});
                chk("cout", {31'd0, cout_out}, {31'd0, e.c});
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", {31'd0, ovf_out}, {31'd0, e.o});
`endif
                // done appears in the 9th cycle after the accepting edge
                chk("done_latency", cyc, e.acc + 8);
            end
        end
    end

    task automatic push(input logic [7:0] s, input logic c, input logic o, input int acc);
        exp_t e;
        e.s = s; e.c = c; e.o = o; e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic add(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] s, input logic c, input logic o);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = ci; start = 1'b1;
        push(s, c, o, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum_out}, 32'd0);
        chk("rst_cout", {31'd0, cout_out}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", {31'd0, ovf_out}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start = 1'b1;
        push(8'h46, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_shift", {31'd0, busy}, 32'd1);
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);

        // reset in the 4th SHIFT cycle aborts without a done pulse
        a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {24'd0, sum_out}, 32'd0);
        chk("abort_cout", {31'd0, cout_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        // start held for 30 cycles: three adds, one every 10 cycles
        @(negedge clk);
        start = 1'b1;
        base = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin a_in = 8'h21; b_in = 8'h13; cin_in = 1'b1; push(8'h35, 1'b0, 1'b0, base); end
                1: begin a_in = 8'hC8; b_in = 8'h64; cin_in = 1'b0; push(8'h2C, 1'b1, 1'b0, base + 10); end
                default: begin a_in = 8'h40; b_in = 8'h40; cin_in = 1'b0; push(8'h80, 1'b0, 1'b1, base + 20); end
            endcase
            repeat (10) @(negedge clk);
        end
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
